// File: rtl/sdu_pkg.sv
// Shared types and helpers for the serial debug unit probe dump engine.
package sdu_pkg;

    typedef enum logic [2:0] {
        IDLE, IDX, COLON, DATA, CR, LF, NEXT, FIN
    } state_t;

    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_BANG  = 8'h21;

    function automatic logic [7:0] hex2asc(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdu_hex_ser.sv
// Presents the top ndig nibbles of a word as uppercase ASCII hex, MSB first,
// one digit per valid/ready transfer.
module sdu_hex_ser
    import sdu_pkg::*;
#(
    parameter int SW = 32,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [SW-1:0] word,
    input  logic [CW-1:0] ndig,
    input  logic          ready,
    output logic [7:0]    data,
    output logic          valid,
    output logic          last
);

    logic [SW-1:0] sh;
    logic [CW-1:0] cnt;

    // The digit on offer is always the top nibble; a transfer shifts the next one up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= word;
            cnt <= ndig;
        end else if (valid && ready) begin
            sh  <= sh << 4;
            cnt <= cnt - 1'b1;
        end
    end

    assign valid = (cnt != '0);
    assign last  = (cnt == CW'(1));
    assign data  = hex2asc(sh[SW-1 -: 4]);

endmodule

// File: rtl/sdu_probe_dump.sv
// Snapshot NCH probe channels on a start pulse and stream one or all of them
// as "<idx>:<hex>\r\n" lines into a byte-wide valid/ready sink.
module sdu_probe_dump
    import sdu_pkg::*;
#(
    parameter int NCH  = 16,
    parameter int DW   = 32,
    parameter int SELW = $clog2(NCH),
    parameter int IDXD = (SELW + 3) / 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [SELW-1:0]     ch_sel,
    input  logic [NCH*DW-1:0]   probe,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int SW   = imax(DW, 4 * IDXD);
    localparam int MAXD = imax(IDXD, DW / 4);
    localparam int CW   = $clog2(MAXD + 1);
    localparam logic [SELW:0] NCH_W   = (SELW + 1)'(NCH);
    localparam logic [SELW:0] LAST_CH = (SELW + 1)'(NCH - 1);

    state_t              state, state_n;
    logic [SELW:0]       c, c_n;
    logic                mode_r, bad_r;
    logic [NCH*DW-1:0]   snap;
    logic [DW-1:0]       snap_word;
    logic                accept, bad_in;

    logic                ser_ld, ser_ready, ser_valid, ser_last;
    logic [SW-1:0]       ld_word;
    logic [CW-1:0]       ld_ndig;
    logic [7:0]          ser_data;

    // The index field is left-aligned in the serializer word so it shifts out MSB first.
    function automatic logic [SW-1:0] idx_word(input logic [SELW:0] v);
        logic [4*IDXD-1:0] f;
        f = (4 * IDXD)'(v);
        return SW'(f) << (SW - 4 * IDXD);
    endfunction

    assign accept    = (state == IDLE) && start;
    assign bad_in    = !mode && ({1'b0, ch_sel} >= NCH_W);
    assign snap_word = snap[c[SELW-1:0]*DW +: DW];
    assign ser_ready = tx_ready && ((state == IDX) || (state == DATA));
    assign busy      = (state != IDLE) && (state != FIN);
    assign done      = (state == FIN);

    sdu_hex_ser #(.SW(SW), .CW(CW)) u_ser (
        .clk   (clk),
        .rst   (rst),
        .load  (ser_ld),
        .word  (ld_word),
        .ndig  (ld_ndig),
        .ready (ser_ready),
        .data  (ser_data),
        .valid (ser_valid),
        .last  (ser_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            c      <= '0;
            mode_r <= 1'b0;
            bad_r  <= 1'b0;
            snap   <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            c     <= c_n;
            if (accept) begin
                snap   <= probe;
                mode_r <= mode;
                bad_r  <= bad_in;
                err    <= 1'b0;
            end else if ((state == COLON) && bad_r && tx_ready) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        c_n      = c;
        ser_ld   = 1'b0;
        ld_word  = '0;
        ld_ndig  = '0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bad_in) begin
                        // Out-of-range select reuses COLON to emit '!' then CR LF.
                        state_n = COLON;
                        c_n     = '0;
                    end else begin
                        state_n = IDX;
                        c_n     = mode ? '0 : {1'b0, ch_sel};
                        ser_ld  = 1'b1;
                        ld_word = idx_word(c_n);
                        ld_ndig = CW'(IDXD);
                    end
                end
            end
            IDX: begin
                tx_valid = ser_valid;
                tx_data  = ser_data;
                if (tx_ready && ser_valid && ser_last) state_n = COLON;
            end
            COLON: begin
                tx_valid = 1'b1;
                tx_data  = bad_r ? ASC_BANG : ASC_COLON;
                if (tx_ready) begin
                    if (bad_r) begin
                        state_n = CR;
                    end else begin
                        state_n = DATA;
                        ser_ld  = 1'b1;
                        ld_word = SW'(snap_word) << (SW - DW);
                        ld_ndig = CW'(DW / 4);
                    end
                end
            end
            DATA: begin
                tx_valid = ser_valid;
                tx_data  = ser_data;
                if (tx_ready && ser_valid && ser_last) state_n = CR;
            end
            CR: begin
                tx_valid = 1'b1;
                tx_data  = ASC_CR;
                if (tx_ready) state_n = LF;
            end
            LF: begin
                tx_valid = 1'b1;
                tx_data  = ASC_LF;
                // The NEXT decision is folded into the LF transfer so lines run back to back.
                if (tx_ready) begin
                    if (mode_r && !bad_r && (c < LAST_CH)) begin
                        state_n = IDX;
                        c_n     = c + 1'b1;
                        ser_ld  = 1'b1;
                        ld_word = idx_word(c_n);
                        ld_ndig = CW'(IDXD);
                    end else begin
                        state_n = FIN;
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdu_probe_dump.sv
// Bench for sdu_probe_dump: a 4-channel and a 5-channel instance, 16-bit probes.
module tb_sdu_probe_dump;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_ready = 1'b1;
    always #5 clk = ~clk;

    logic        start4 = 1'b0, mode4 = 1'b0;
    logic [1:0]  sel4 = '0;
    logic [63:0] probe4 = '0;
    logic [7:0]  d4;
    logic        v4, busy4, done4, err4;

    logic        start5 = 1'b0, mode5 = 1'b0;
    logic [2:0]  sel5 = '0;
    logic [79:0] probe5 = '0;
    logic [7:0]  d5;
    logic        v5, busy5, done5, err5;

    sdu_probe_dump #(.NCH(4), .DW(16)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .ch_sel(sel4),
        .probe(probe4), .tx_data(d4), .tx_valid(v4), .tx_ready(tx_ready),
        .busy(busy4), .done(done4), .err(err4)
    );

    sdu_probe_dump #(.NCH(5), .DW(16)) u_dut5 (
        .clk(clk), .rst(rst), .start(start5), .mode(mode5), .ch_sel(sel5),
        .probe(probe5), .tx_data(d5), .tx_valid(v5), .tx_ready(tx_ready),
        .busy(busy5), .done(done5), .err(err5)
    );

    logic       use5 = 1'b0;
    logic [7:0] m_data;
    logic       m_valid, m_busy, m_done;
    assign m_data  = use5 ? d5 : d4;
    assign m_valid = use5 ? v5 : v4;
    assign m_busy  = use5 ? busy5 : busy4;
    assign m_done  = use5 ? done5 : done4;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, first_x = -1, last_x = -1, nx = 0;
    int done_cnt = 0, done_cyc = -1, done_base = 0, busy_bad = 0;
    logic [7:0] exp_q[$];
    logic [3:0] rdy_pat = 4'b1111;
    string hx = "0123456789ABCDEF";

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Ready driver: pattern bit (phase mod 4) applied 1ns after every edge.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rdy_pat[ph % 4];
            ph++;
        end
    end

    // Monitor: a byte on offer with ready high transfers at the next rising edge.
    logic       stall_prev = 1'b0;
    logic [7:0] held = '0;
    always @(negedge clk) begin
        if (stall_prev) check(m_valid && (m_data == held), "stall_hold", {m_valid, m_data}, {1'b1, held});
        if (m_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_byte", m_data, 0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check(m_data == e, "byte", m_data, e);
            end
            if (first_x < 0) first_x = cyc + 1;
            last_x = cyc + 1;
            nx++;
        end
        stall_prev = m_valid && !tx_ready;
        held = m_data;
        if (m_valid && !m_busy) busy_bad++;
        if (m_done) begin
            done_cnt++;
            done_cyc = cyc;
            check(!m_busy, "busy_low_at_done", m_busy, 0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_line(input int c, input logic [15:0] v);
        exp_q.push_back(hx[c]);
        exp_q.push_back(8'h3A);
        for (int i = 3; i >= 0; i--) exp_q.push_back(hx[v[i*4 +: 4]]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic start_pulse(input bit is5, input bit m, input logic [2:0] s);
        done_base = done_cnt;
        first_x = -1;
        nx = 0;
        busy_bad = 0;
        @(posedge clk);
        #1;
        if (is5) begin start5 = 1'b1; mode5 = m; sel5 = s; end
        else     begin start4 = 1'b1; mode4 = m; sel4 = s[1:0]; end
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start5 = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int nbytes, input bit gapfree);
        for (int i = 0; i < 400 && done_cnt == done_base; i++) step();
        check(done_cnt == done_base + 1, {tag, "_done_count"}, done_cnt - done_base, 1);
        check(exp_q.size() == 0, {tag, "_queue_drained"}, exp_q.size(), 0);
        check(nx == nbytes, {tag, "_byte_count"}, nx, nbytes);
        check(done_cyc == last_x, {tag, "_done_after_last"}, done_cyc, last_x);
        check(busy_bad == 0, {tag, "_busy_during_dump"}, busy_bad, 0);
        if (gapfree) check(last_x - first_x == nbytes - 1, {tag, "_gap_free"}, last_x - first_x, nbytes - 1);
    endtask

    typedef struct packed {
        logic        mode;
        logic [1:0]  sel;
        logic [63:0] probe;
        logic [3:0]  pat;
        logic [5:0]  nbytes;
    } vec_t;

    vec_t vt[6];

    task automatic run_vec4(input vec_t v, input string tag);
        rdy_pat = v.pat;
        probe4  = v.probe;
        if (v.mode) for (int c = 0; c < 4; c++) push_line(c, v.probe[c*16 +: 16]);
        else push_line(int'(v.sel), v.probe[int'(v.sel)*16 +: 16]);
        start_pulse(1'b0, v.mode, {1'b0, v.sel});
        wait_done(tag, int'(v.nbytes), v.pat == 4'b1111);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{mode: 1'b0, sel: 2'd2, probe: 64'h1111_BEEF_2222_3333, pat: 4'b1111, nbytes: 6'd8};
        vt[1] = '{mode: 1'b1, sel: 2'd0, probe: 64'h4000_0300_0020_0001, pat: 4'b1111, nbytes: 6'd32};
        vt[2] = '{mode: 1'b0, sel: 2'd2, probe: 64'h1111_BEEF_2222_3333, pat: 4'b1001, nbytes: 6'd8};
        vt[3] = '{mode: 1'b0, sel: 2'd0, probe: 64'h0000_0000_0000_A5C3, pat: 4'b1111, nbytes: 6'd8};
        vt[4] = '{mode: 1'b1, sel: 2'd3, probe: 64'hFFFF_0000_9ABC_1234, pat: 4'b1001, nbytes: 6'd32};
        vt[5] = '{mode: 1'b0, sel: 2'd3, probe: 64'h7E01_D00D_CAFE_0F0F, pat: 4'b1111, nbytes: 6'd8};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check(v4 == 1'b0 && busy4 == 1'b0, "reset_valid_busy", {v4, busy4}, 0);
        check(done4 == 1'b0 && err4 == 1'b0, "reset_done_err", {done4, err4}, 0);
        check(d4 == 8'h00, "reset_tx_data", d4, 0);
        check(v5 == 1'b0 && busy5 == 1'b0 && d5 == 8'h00, "reset_dut5", {v5, busy5, d5}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) run_vec4(vt[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) begin
            vec_t r;
            r.mode   = 1'($urandom_range(0, 1));
            r.sel    = 2'($urandom_range(0, 3));
            r.probe  = {$urandom(), $urandom()};
            r.pat    = ($urandom_range(0, 1) == 1) ? 4'b1001 : 4'b1111;
            r.nbytes = r.mode ? 6'd32 : 6'd8;
            run_vec4(r, $sformatf("rand%0d", i));
        end

        // Snapshot coherence: probe changes and a second start one cycle later are ignored.
        rdy_pat = 4'b1111;
        probe4 = 64'h1111_BEEF_2222_3333;
        push_line(2, 16'hBEEF);
        start_pulse(1'b0, 1'b0, 3'd2);
        probe4[47:32] = 16'h1234;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        wait_done("coherence", 8, 1'b1);
        repeat (12) step();
        check(done_cnt == done_base + 1, "second_start_ignored", done_cnt - done_base, 1);

        // Out-of-range select on the 5-channel instance, then a valid start clears err.
        use5 = 1'b1;
        probe5 = {16'hC0DE, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        start_pulse(1'b1, 1'b0, 3'd7);
        wait_done("bad_sel", 3, 1'b1);
        step();
        check(err5 == 1'b1, "err_set", err5, 1);
        push_line(4, 16'hC0DE);
        start_pulse(1'b1, 1'b0, 3'd4);
        check(err5 == 1'b0, "err_cleared", err5, 0);
        wait_done("ch4_nch5", 8, 1'b1);
        for (int c = 0; c < 5; c++) push_line(c, probe5[c*16 +: 16]);
        start_pulse(1'b1, 1'b1, 3'd0);
        wait_done("all_nch5", 40, 1'b1);
        use5 = 1'b0;

        // Reset mid-dump, after the third byte has transferred.
        probe4 = 64'h1111_BEEF_2222_3333;
        push_line(2, 16'hBEEF);
        start_pulse(1'b0, 1'b0, 3'd2);
        for (int i = 0; i < 50 && nx < 3; i++) step();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(v4 == 1'b0 && busy4 == 1'b0, "abort_valid_busy", {v4, busy4}, 0);
        check(d4 == 8'h00, "abort_tx_data", d4, 0);
        exp_q.delete();
        done_base = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) step();
        check(done_cnt == done_base, "no_done_after_abort", done_cnt - done_base, 0);
        run_vec4(vt[0], "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
